// File: rtl/video_timing_pkg.sv
// Raster timing presets and window-bound helper
// shared by the video timing generator.
package video_timing_pkg;

  typedef struct packed {
    int unsigned total;
    int unsigned sync_lo;
    int unsigned sync_hi;
  } axis_t;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int VGA640_H_DISPLAY = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_DISPLAY = 480;
  localparam int VGA640_V_BOTTOM  = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_TOP     = 33;

  // 800x600@60, 40 MHz pixel clock
  localparam int SVGA800_H_DISPLAY = 800;
  localparam int SVGA800_H_FRONT   = 40;
  localparam int SVGA800_H_SYNC    = 128;
  localparam int SVGA800_H_BACK    = 88;
  localparam int SVGA800_V_DISPLAY = 600;
  localparam int SVGA800_V_BOTTOM  = 1;
  localparam int SVGA800_V_SYNC    = 4;
  localparam int SVGA800_V_TOP     = 23;

  function automatic axis_t axis_bounds(
    input int unsigned disp,
    input int unsigned front,
    input int unsigned sync,
    input int unsigned back
  );
    axis_t a;
    a.total   = disp + front + sync + back;
    a.sync_lo = disp + front;
    a.sync_hi = disp + front + sync - 1;
    return a;
  endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: mod-N counter with registered
// sync level, next-position active flag and wrap.
module vtg_axis_counter #(
  parameter int CW      = 10,
  parameter int N       = 800,
  parameter int ACT     = 640,
  parameter int SYNC_LO = 656,
  parameter int SYNC_HI = 751,
  parameter bit POL     = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          sync_o,
  output logic          act_nxt_o,
  output logic          wrap_o
);

  localparam logic [CW-1:0] LAST  = CW'(N - 1);
  localparam logic [CW-1:0] A_END = CW'(ACT);
  localparam logic [CW-1:0] S_LO  = CW'(SYNC_LO);
  localparam logic [CW-1:0] S_HI  = CW'(SYNC_HI);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync_q, sync_d;

  assign wrap_o = en_i && (cnt_q == LAST);

  // Flags derive from the next count so they land
  // in the same cycle as the position they describe.
  always_comb begin
    cnt_d = cnt_q;
    if (wrap_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
    sync_d = ((cnt_d >= S_LO) && (cnt_d <= S_HI)) ? POL : !POL;
  end

  assign act_nxt_o = (cnt_d < A_END);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      sync_q <= !POL;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign sync_o = sync_q;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with strobes.
// Define VTG_FRAME_COUNT_EN to build the frame counter.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_BOTTOM   = 10,
  parameter int V_SYNC     = 2,
  parameter int V_TOP      = 33,
  parameter bit H_SYNC_POL = 1'b1,
  parameter bit V_SYNC_POL = 1'b1,
  parameter int CW         = 10,
  parameter int FRAME_W    = 12,
  parameter int FRAME_INIT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic [CW-1:0]      hpos,
  output logic [CW-1:0]      vpos,
  output logic               line_start,
  output logic               frame_start,
  output logic               vblank_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam axis_t HAX =
    axis_bounds(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam axis_t VAX =
    axis_bounds(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP);
  localparam logic [CW-1:0] V_BLANK_AT = CW'(V_DISPLAY - 1);

  if ($clog2(HAX.total) > CW) begin : g_bad_h
    $error("H_TOTAL-1 does not fit in CW bits");
  end
  if ($clog2(VAX.total) > CW) begin : g_bad_v
    $error("V_TOTAL-1 does not fit in CW bits");
  end
  if ($clog2(FRAME_INIT + 1) > FRAME_W) begin : g_bad_f
    $error("FRAME_INIT does not fit in FRAME_W bits");
  end

  logic h_act, h_wrap, v_act, v_wrap;

  vtg_axis_counter #(
    .CW(CW), .N(HAX.total), .ACT(H_DISPLAY),
    .SYNC_LO(HAX.sync_lo), .SYNC_HI(HAX.sync_hi),
    .POL(H_SYNC_POL)
  ) u_h (
    .clk_i(clk), .rst_i(reset), .en_i(pix_en),
    .cnt_o(hpos), .sync_o(hsync),
    .act_nxt_o(h_act), .wrap_o(h_wrap)
  );

  vtg_axis_counter #(
    .CW(CW), .N(VAX.total), .ACT(V_DISPLAY),
    .SYNC_LO(VAX.sync_lo), .SYNC_HI(VAX.sync_hi),
    .POL(V_SYNC_POL)
  ) u_v (
    .clk_i(clk), .rst_i(reset), .en_i(h_wrap),
    .cnt_o(vpos), .sync_o(vsync),
    .act_nxt_o(v_act), .wrap_o(v_wrap)
  );

  logic disp_q, disp_d;
  logic line_q, line_d;
  logic frame_q, frame_d;
  logic vblank_q, vblank_d;

  // h_wrap already carries pix_en, so strobes drop
  // to zero on every stalled cycle.
  always_comb begin
    disp_d   = h_act & v_act;
    line_d   = h_wrap;
    frame_d  = v_wrap;
    vblank_d = h_wrap & (vpos == V_BLANK_AT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q   <= 1'b1;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      disp_q   <= disp_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
      vblank_q <= vblank_d;
    end
  end

  assign display_on   = disp_q;
  assign line_start   = line_q;
  assign frame_start  = frame_q;
  assign vblank_start = vblank_q;

`ifdef VTG_FRAME_COUNT_EN
  logic [FRAME_W-1:0] fc_q, fc_d;

  assign fc_d = frame_d ? fc_q + FRAME_W'(1) : fc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fc_q <= FRAME_W'(FRAME_INIT);
    end else begin
      fc_q <= fc_d;
    end
  end

  assign frame_count = fc_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 line checks plus a
// tiny raster for full-frame, stall and reset cases.
module tb_video_timing_gen;

  localparam int BHT    = 14;
  localparam int BVT    = 10;
  localparam int B_INIT = 2;
`ifdef VTG_FRAME_COUNT_EN
  localparam int FC17 = 3;
  localparam int FCI  = B_INIT;
`else
  localparam int FC17 = 0;
  localparam int FCI  = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, en_a = 1'b1;
  logic rst_b = 1'b1, en_b = 1'b1;

  logic        hs_a, vs_a, de_a, ls_a, fs_a, vb_a;
  logic [9:0]  hp_a, vp_a;
  logic [11:0] fc_a;
  logic        hs_b, vs_b, de_b, ls_b, fs_b, vb_b;
  logic [3:0]  hp_b, vp_b, fc_b;

  video_timing_gen u_a (
    .clk(clk), .reset(rst_a), .pix_en(en_a),
    .hsync(hs_a), .vsync(vs_a), .display_on(de_a),
    .hpos(hp_a), .vpos(vp_a),
    .line_start(ls_a), .frame_start(fs_a),
    .vblank_start(vb_a), .frame_count(fc_a)
  );

  video_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_DISPLAY(6), .V_BOTTOM(1), .V_SYNC(2), .V_TOP(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
    .CW(4), .FRAME_W(4), .FRAME_INIT(B_INIT)
  ) u_b (
    .clk(clk), .reset(rst_b), .pix_en(en_b),
    .hsync(hs_b), .vsync(vs_b), .display_on(de_b),
    .hpos(hp_b), .vpos(vp_b),
    .line_start(ls_b), .frame_start(fs_b),
    .vblank_start(vb_b), .frame_count(fc_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int mh, mv, mfc;
  logic mls, mfs, mvb;
  int cyc, n_fs, n_vb, n_ls, n_de, n_hsl, n_vsl;
  int fs_prev, fs_last, ls_prev, ls_last;

  task automatic step_b(input logic r, input logic e);
    logic e_hs, e_vs, e_de;
    rst_b = r;
    en_b  = e;
    tick();
    cyc++;
    if (r) begin
      mh = 0; mv = 0; mfc = B_INIT;
      mls = 0; mfs = 0; mvb = 0;
    end else if (e) begin
      mls = (mh == BHT - 1);
      mfs = mls && (mv == BVT - 1);
      mvb = mls && (mv == 5);
      if (mls) begin
        mh = 0;
        mv = (mv == BVT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
      if (mfs) mfc = (mfc + 1) % 16;
    end else begin
      mls = 0; mfs = 0; mvb = 0;
    end
    e_hs = !(mh >= 10 && mh <= 12);
    e_vs = !(mv >= 7 && mv <= 8);
    e_de = (mh < 8) && (mv < 6);
`ifndef VTG_FRAME_COUNT_EN
    mfc = 0;
`endif
    chk("b_cyc",
        {hp_b, vp_b, hs_b, vs_b, de_b, ls_b, fs_b, vb_b, fc_b},
        {4'(mh), 4'(mv), e_hs, e_vs, e_de,
         mls, mfs, mvb, 4'(mfc)});
    if (fs_b) begin n_fs++; fs_prev = fs_last; fs_last = cyc; end
    if (ls_b) begin n_ls++; ls_prev = ls_last; ls_last = cyc; end
    if (vb_b) n_vb++;
    if (de_b) n_de++;
    if (!hs_b) n_hsl++;
    if (!vs_b) n_vsl++;
  endtask

  task automatic clr_b();
    n_fs = 0; n_vb = 0; n_ls = 0; n_de = 0;
    n_hsl = 0; n_vsl = 0;
    fs_prev = 0; fs_last = 0; ls_prev = 0; ls_last = 0;
  endtask

  initial begin
    int hs_n, de_n, hs_lo, hs_hi, de_fall;
    int ls_n, ls_c0, ls_c1, v1_h, bad, n;
    hs_n = 0; de_n = 0; hs_lo = -1; hs_hi = -1;
    de_fall = -1; ls_n = 0; ls_c0 = -1; ls_c1 = -1;
    v1_h = -1; bad = 0; cyc = 0;

    // default raster: reset state and first cycle
    repeat (3) tick();
    chk("a_rst",
        {hp_a, vp_a, hs_a, vs_a, de_a, ls_a, fs_a, vb_a, fc_a},
        {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 3'b000, 12'd0});
    rst_a = 1'b0;
    tick();
    chk("a_first", {hp_a, vp_a, ls_a, fs_a, vb_a},
        {10'd1, 10'd0, 3'b000});

    // two default lines
    for (int k = 0; k < 1600; k++) begin
      tick();
      if (k < 800) begin
        if (hs_a) begin
          hs_n++;
          if (hs_lo < 0) hs_lo = int'(hp_a);
          hs_hi = int'(hp_a);
        end
        if (de_a) de_n++;
        else if (de_fall < 0) de_fall = int'(hp_a);
      end
      if (ls_a) begin
        if (ls_n == 0) ls_c0 = k;
        else ls_c1 = k;
        ls_n++;
      end
      if (ls_a != (hp_a == 10'd0)) bad++;
      if (vp_a == 10'd1 && v1_h < 0) v1_h = int'(hp_a);
      if (fs_a || vb_a || vs_a) bad++;
    end
    chk("a_hs_width", hs_n, 96);
    chk("a_hs_first", hs_lo, 656);
    chk("a_hs_last", hs_hi, 751);
    chk("a_de_count", de_n, 640);
    chk("a_de_fall", de_fall, 640);
    chk("a_ls_count", ls_n, 2);
    chk("a_ls_first", ls_c0, 798);
    chk("a_ls_period", ls_c1 - ls_c0, 800);
    chk("a_vpos_wrap_h", v1_h, 0);
    chk("a_misc_bad", bad, 0);

    // tiny raster: 14 x 10, 140 pixels per frame
    clr_b();
    repeat (3) step_b(1'b1, 1'b1);
    chk("b_rst", {hp_b, vp_b, hs_b, vs_b, de_b,
                  ls_b, fs_b, vb_b, fc_b},
        {4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 3'b000, 4'(FCI)});

    clr_b();
    repeat (17 * BHT * BVT) step_b(1'b0, 1'b1);
    chk("b_fs_count", n_fs, 17);
    chk("b_fs_period", fs_last - fs_prev, 140);
    chk("b_vb_count", n_vb, 17);
    chk("b_de_count", n_de, 17 * 48);
    chk("b_hs_low", n_hsl, 17 * 30);
    chk("b_vs_low", n_vsl, 17 * 28);
    chk("b_fc_17", fc_b, FC17);

    // stalled every other cycle
    clr_b();
    for (int i = 0; i < 60; i++) step_b(1'b0, (i % 2) == 0);
    chk("b_stall_ls_n", n_ls, 2);
    chk("b_stall_ls_per", ls_last - ls_prev, 2 * BHT);

    // mid-frame reset
    n = 0;
    while (!(mh == 5 && mv == 4) && n < 200) begin
      step_b(1'b0, 1'b1);
      n++;
    end
    chk("b_reach_mid", {hp_b, vp_b}, {4'd5, 4'd4});
    step_b(1'b1, 1'b1);
    chk("b_mid_rst", {hp_b, vp_b, ls_b, fs_b, vb_b, fc_b},
        {4'd0, 4'd0, 3'b000, 4'(FCI)});
    n = 0;
    do begin
      step_b(1'b0, 1'b1);
      n++;
    end while (!fs_b && n < 300);
    chk("b_fs_after_rst", n, 140);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
